// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver for the processor console line.
// Mid-bit sampling, bytes buffered in a first-word-fall-through FIFO.
module uart_rx_monitor #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               UART_RXD,
  output logic [7:0]         RX_DATA,
  output logic               RX_VALID,
  input  logic               RX_READY,
  output logic               FRAME_ERR,
  output logic               OVERRUN,
  output logic [FIFO_AW:0]   FIFO_COUNT
);

  localparam int unsigned TW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned DEPTH = 1 << FIFO_AW;

  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t state, state_n;

  logic          rxs_meta;
  logic          rxs;
  logic [TW-1:0] tmr, tmr_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          push;
  logic          ferr;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rxs_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxs_meta <= UART_RXD;
      rxs      <= rxs_meta;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state  <= IDLE;
      tmr    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      state  <= state_n;
      tmr    <= tmr_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
    end
  end

  always_comb begin
    state_n  = state;
    tmr_n    = tmr;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    push     = 1'b0;
    ferr     = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          tmr_n   = HALF;
          state_n = START;
        end
      end
      START: begin
        if (tmr != '0) begin
          tmr_n = tmr - TW'(1);
        end else if (rxs) begin
          state_n = IDLE;
        end else begin
          tmr_n    = FULL;
          bitcnt_n = '0;
          state_n  = DATA;
        end
      end
      DATA: begin
        if (tmr != '0) begin
          tmr_n = tmr - TW'(1);
        end else begin
          shreg_n  = {rxs, shreg[7:1]};
          tmr_n    = FULL;
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7)
            state_n = STOP;
        end
      end
      STOP: begin
        if (tmr != '0) begin
          tmr_n = tmr - TW'(1);
        end else if (rxs) begin
          push    = 1'b1;
          state_n = IDLE;
        end else begin
          ferr    = 1'b1;
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rxs)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign FIFO_COUNT = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (FIFO_COUNT == CNT_FULL);
  assign do_pop     = RX_READY && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push    = push && (!full || do_pop);
  assign drop       = push && full && !do_pop;

  always_ff @(posedge CLK) begin
    if (do_push)
      mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      FRAME_ERR <= ferr;
      OVERRUN   <= drop;
    end
  end

  assign RX_VALID = !empty;
  assign RX_DATA  = empty ? 8'h00 : mem[rd_ptr[FIFO_AW-1:0]];

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: scoreboard of sent bytes vs popped bytes,
// plus flag counters checked per scenario.
module tb_uart_rx_monitor;

  localparam int CPB = 16;

  logic       CLK;
  logic       RESET;
  logic       UART_RXD;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;
  logic       FRAME_ERR;
  logic       OVERRUN;
  logic [4:0] FIFO_COUNT;

  uart_rx_monitor #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW(4)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .UART_RXD(UART_RXD),
    .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID),
    .RX_READY(RX_READY),
    .FRAME_ERR(FRAME_ERR),
    .OVERRUN(OVERRUN),
    .FIFO_COUNT(FIFO_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] sb[$];
  int n_chk   = 0;
  int n_pass  = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int pop_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge CLK) begin
    if (RESET) begin
      if (FRAME_ERR) ferr_cnt++;
      if (OVERRUN) ovr_cnt++;
      if (RX_VALID && RX_READY) begin
        pop_cnt++;
        if (sb.size() == 0)
          check("unexpected_pop", 32'(RX_DATA), 32'h100);
        else
          check("rx_data", 32'(RX_DATA), 32'(sb.pop_front()));
      end
    end
  end

  task automatic drive_bit(input logic b, input int n);
    UART_RXD = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic expect_push);
    if (expect_push) sb.push_back(b);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop_bit, CPB);
  endtask

  task automatic pop_one();
    RX_READY = 1'b1;
    @(posedge CLK);
    #1;
    RX_READY = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    RX_READY = 1'b1;
    while (RX_VALID && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    RX_READY = 1'b0;
    check("drain_done", 32'(RX_VALID), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  string hw = "Hello World\r\n";

  initial begin
    RESET    = 1'b0;
    UART_RXD = 1'b1;
    RX_READY = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_count", 32'(FIFO_COUNT), 32'd0);
    check("rst_valid", 32'(RX_VALID), 32'd0);
    check("rst_data", 32'(RX_DATA), 32'd0);
    check("rst_flags", 32'({FRAME_ERR, OVERRUN}), 32'd0);
    RESET = 1'b1;
    drive_bit(1'b1, 10);

    // 1: two bytes, then single pops
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hA3, 1'b1, 1'b1);
    drive_bit(1'b1, 4);
    check("t1_count", 32'(FIFO_COUNT), 32'd2);
    check("t1_head0", 32'(RX_DATA), 32'h55);
    pop_one();
    check("t1_head1", 32'(RX_DATA), 32'hA3);
    check("t1_count1", 32'(FIFO_COUNT), 32'd1);
    pop_one();
    check("t1_valid", 32'(RX_VALID), 32'd0);
    check("t1_sb", 32'(sb.size()), 32'd0);

    // 2: short glitch rejected
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 40);
    check("t2_count", 32'(FIFO_COUNT), 32'd0);
    check("t2_ferr", 32'(ferr_cnt), 32'd0);
    check("t2_ovr", 32'(ovr_cnt), 32'd0);

    // 3: framing error with stuck-low line, then recovery
    send_frame(8'h41, 1'b0, 1'b0);
    drive_bit(1'b0, 40 - CPB);
    drive_bit(1'b1, 20);
    check("t3_ferr", 32'(ferr_cnt), 32'd1);
    check("t3_count", 32'(FIFO_COUNT), 32'd0);
    send_frame(8'h42, 1'b1, 1'b1);
    drive_bit(1'b1, 4);
    check("t3_count2", 32'(FIFO_COUNT), 32'd1);
    check("t3_head", 32'(RX_DATA), 32'h42);
    drain();
    check("t3_ferr2", 32'(ferr_cnt), 32'd1);

    // 4: overrun on the 17th byte
    for (int i = 0; i < 17; i++)
      send_frame(8'(i), 1'b1, i < 16);
    drive_bit(1'b1, 4);
    check("t4_count", 32'(FIFO_COUNT), 32'd16);
    check("t4_ovr", 32'(ovr_cnt), 32'd1);
    check("t4_head", 32'(RX_DATA), 32'h00);
    drain();
    check("t4_sb", 32'(sb.size()), 32'd0);
    check("t4_ferr", 32'(ferr_cnt), 32'd1);

    // 5: reset mid-frame discards buffered and in-flight bytes
    send_frame(8'h99, 1'b1, 1'b0);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, 5);
    RESET    = 1'b0;
    UART_RXD = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check("t5_rst_count", 32'(FIFO_COUNT), 32'd0);
    check("t5_rst_data", 32'(RX_DATA), 32'd0);
    RESET = 1'b1;
    drive_bit(1'b1, 20);
    send_frame(8'h31, 1'b1, 1'b1);
    drive_bit(1'b1, 4);
    check("t5_count", 32'(FIFO_COUNT), 32'd1);
    check("t5_head", 32'(RX_DATA), 32'h31);
    drain();
    check("t5_ferr", 32'(ferr_cnt), 32'd1);

    // 6: back-to-back stream with consumer always ready
    pop_cnt  = 0;
    RX_READY = 1'b1;
    for (int i = 0; i < hw.len(); i++)
      send_frame(hw[i], 1'b1, 1'b1);
    drive_bit(1'b1, 40);
    RX_READY = 1'b0;
    check("t6_pops", 32'(pop_cnt), 32'd13);
    check("t6_sb", 32'(sb.size()), 32'd0);
    check("t6_ferr", 32'(ferr_cnt), 32'd1);
    check("t6_ovr", 32'(ovr_cnt), 32'd1);
    check("t6_count", 32'(FIFO_COUNT), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
